// File: rtl/seq_det_pkg.sv
// Shared state encoding and default sizing for the serial-detector scheduler.
package seq_det_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int NREQ_DEF    = 4;
    localparam int FRAME_W_DEF = 8;
    localparam int DET_LAT_DEF = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request after the last winner, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    en_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    vld_o
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] last_q;

    // Scan farthest-first so the nearest requester after last_q wins.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        vld_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        j     = 0;
        jj    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j  = (int'(last_q) + k) % NREQ;
            jj = IW'(j);
            if (req_i[jj]) begin
                vld_o = 1'b1;
                idx_o = jj;
            end
        end
        if (vld_o) gnt_o[idx_o] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              last_q <= IW'(NREQ - 1);
        else if (en_i && vld_o)  last_q <= idx_o;
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one serial pattern detector among NREQ requesters, one frame at a time.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DET_LAT = DET_LAT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*FRAME_W-1:0]      data_in,
    output logic [NREQ-1:0]              ack,
    output logic [$clog2(FRAME_W+1)-1:0] hit_cnt,
    output logic                         busy,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic                         det_rst_n,
    output logic                         det_in,
    input  logic                         det_out
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FRAME_W + 1);
    localparam int TW = $clog2(FRAME_W + DET_LAT + 1);
    localparam logic [TW-1:0] SHIFT_LAST = TW'(FRAME_W - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(FRAME_W + DET_LAT - 1);
    localparam logic [TW-1:0] SAMP_FIRST = TW'(DET_LAT);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] sreg_q;
    logic [TW-1:0]      cyc_q;
    logic [CW-1:0]      hit_q;
    logic [IW-1:0]      gid_q;
    logic [NREQ-1:0]    goh_q;

    logic               arb_en, arb_vld, samp;
    logic [NREQ-1:0]    arb_gnt;
    logic [IW-1:0]      arb_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req_i (req),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                arb_en = 1'b1;
                if (arb_vld) state_d = S_CLR;
            end
            S_CLR:   state_d = S_SHIFT;
            S_SHIFT: if (cyc_q == SHIFT_LAST) state_d = S_DRAIN;
            S_DRAIN: if (cyc_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // cyc_q counts from the first SHIFT cycle; det_out lags det_in by DET_LAT.
    assign samp = (cyc_q >= SAMP_FIRST) && det_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cyc_q   <= '0;
            hit_q   <= '0;
            gid_q   <= '0;
            goh_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (arb_vld) begin
                    sreg_q <= data_in[arb_idx*FRAME_W +: FRAME_W];
                    gid_q  <= arb_idx;
                    goh_q  <= arb_gnt;
                end
                S_CLR: begin
                    cyc_q <= '0;
                    hit_q <= '0;
                end
                S_SHIFT: begin
                    sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
                    cyc_q  <= cyc_q + TW'(1);
                    if (samp) hit_q <= hit_q + CW'(1);
                end
                S_DRAIN: begin
                    cyc_q <= cyc_q + TW'(1);
                    if (samp) hit_q <= hit_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign ack       = (state_q == S_DONE) ? goh_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = gid_q;
    assign hit_cnt   = hit_q;
    assign det_rst_n = (state_q == S_SHIFT) || (state_q == S_DRAIN);
    assign det_in    = (state_q == S_SHIFT) && sreg_q[FRAME_W-1];

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench: overlapping "101" Moore detector model, table of frames plus corner sequences.
module tb_seq_det_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  ack;
    logic [3:0]  hit_cnt;
    logic        busy;
    logic [1:0]  grant_id;
    logic        det_rst_n, det_in, det_out;
    logic [1:0]  ds = 2'd0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_det_scheduler #(.NREQ(4), .FRAME_W(8), .DET_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .hit_cnt   (hit_cnt),
        .busy      (busy),
        .grant_id  (grant_id),
        .det_rst_n (det_rst_n),
        .det_in    (det_in),
        .det_out   (det_out)
    );

    // Detector states: 0 none, 1 seen "1", 2 seen "10", 3 seen "101" (output high).
    always @(posedge clk) begin
        if (!det_rst_n) ds <= 2'd0;
        else case (ds)
            2'd0:    ds <= det_in ? 2'd1 : 2'd0;
            2'd1:    ds <= det_in ? 2'd1 : 2'd2;
            2'd2:    ds <= det_in ? 2'd3 : 2'd0;
            default: ds <= det_in ? 2'd1 : 2'd2;
        endcase
    end
    assign det_out = (ds == 2'd3);

    typedef struct {
        int         id;
        logic [7:0] word;
        int         hits;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns negedges elapsed until ack is seen; bits = first 8 det_in values with det_rst_n high.
    task automatic wait_ack(input int maxc, output int n, output logic [7:0] bits);
        int nb;
        nb   = 0;
        n    = 0;
        bits = '0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (det_rst_n && nb < 8) begin
                bits = {bits[6:0], det_in};
                nb++;
            end
            if (ack != 4'b0000) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL ack_timeout: no ack within %0d cycles", maxc);
        n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] bits;
        int         exp_id[5];
        int         exp_hit[5];

        vt[0] = '{2, 8'hAA, 3};
        vt[1] = '{1, 8'h00, 0};
        vt[2] = '{1, 8'hB5, 3};   // 1,0,1,1,0,1,0,1: overlapping hits at bits 0-2, 3-5, 5-7
        vt[3] = '{3, 8'h55, 3};
        vt[4] = '{0, 8'h85, 1};   // only hit lands on the final bit, seen during DRAIN
        vt[5] = '{2, 8'hA0, 1};
        vt[6] = '{0, 8'hFF, 0};

        // Reset held with all requests pending
        req     = 4'b1111;
        data_in = {8'h55, 8'h85, 8'hB5, 8'hAA};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_det_in", det_in, 0);
        chk("rst_det_rst_n", det_rst_n, 0);
        reset = 1'b1;
        wait_ack(40, n, bits);
        chk("first_ack_cycle", n + 1, 12);
        chk("first_ack", ack, 4'b0001);
        chk("first_gid", grant_id, 0);
        chk("first_hit", hit_cnt, 3);
        chk("first_bits", bits, 8'hAA);
        req = 4'b0000;
        @(negedge clk);
        chk("post_done_ack", ack, 0);
        chk("post_done_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_det_rst_n", det_rst_n, 0);
        chk("idle_hit_hold", hit_cnt, 3);

        // Single-frame table
        for (int i = 0; i < 7; i++) begin
            data_in[vt[i].id*8 +: 8] = vt[i].word;
            req = 4'b0001 << vt[i].id;
            wait_ack(40, n, bits);
            chk($sformatf("v%0d_cycle", i), n + 1, 12);
            chk($sformatf("v%0d_ack", i), ack, 4'b0001 << vt[i].id);
            chk($sformatf("v%0d_gid", i), grant_id, vt[i].id);
            chk($sformatf("v%0d_hit", i), hit_cnt, vt[i].hits);
            chk($sformatf("v%0d_bits", i), bits, vt[i].word);
            req = 4'b0000;
            @(negedge clk);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // Fairness: all requesting, pointer freshly reset
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        data_in = {8'h55, 8'hFF, 8'hA0, 8'hAA};
        req     = 4'b1111;
        exp_id  = '{0, 1, 2, 3, 0};
        exp_hit = '{3, 1, 0, 3, 3};
        for (int k = 0; k < 5; k++) begin
            wait_ack(40, n, bits);
            if (k == 0) chk("rr_first_cycle", n + 1, 12);
            else        chk($sformatf("rr%0d_gap", k), n, 12);
            chk($sformatf("rr%0d_ack", k), ack, 4'b0001 << exp_id[k]);
            chk($sformatf("rr%0d_gid", k), grant_id, exp_id[k]);
            chk($sformatf("rr%0d_hit", k), hit_cnt, exp_hit[k]);
        end
        req = 4'b0000;
        @(negedge clk);

        // Reset during the 4th SHIFT cycle of requester 1
        data_in[15:8] = 8'hAA;
        req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_gid", grant_id, 1);
        chk("mid_det_rst_n", det_rst_n, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        chk("abort_det_rst_n", det_rst_n, 0);
        chk("abort_gid", grant_id, 0);
        chk("abort_det_in", det_in, 0);
        repeat (2) @(negedge clk);
        chk("abort_hold_ack", ack, 0);
        reset = 1'b1;
        wait_ack(40, n, bits);
        chk("reserve_cycle", n + 1, 12);
        chk("reserve_ack", ack, 4'b0010);
        chk("reserve_hit", hit_cnt, 3);
        chk("reserve_bits", bits, 8'hAA);
        req = 4'b0000;
        @(negedge clk);

        // Request churn: req[3] drops and its word changes mid-frame while req[0] rises
        data_in[31:24] = 8'h55;
        req = 4'b1000;
        repeat (5) @(negedge clk);
        req            = 4'b0001;
        data_in[7:0]   = 8'h85;
        data_in[31:24] = 8'h00;
        wait_ack(40, n, bits);
        chk("churn_rest_cycles", n, 6);
        chk("churn_ack", ack, 4'b1000);
        chk("churn_gid", grant_id, 3);
        chk("churn_hit", hit_cnt, 3);
        wait_ack(40, n, bits);
        chk("churn_next_gap", n, 12);
        chk("churn_next_ack", ack, 4'b0001);
        chk("churn_next_gid", grant_id, 0);
        chk("churn_next_hit", hit_cnt, 1);
        chk("churn_next_bits", bits, 8'h85);
        req = 4'b0000;
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_ack", ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
